// File: rtl/rvm_shift_seq_if.sv
// Request/response bundle for the iterative shift/rotate unit.
// The master is the issuing core FSM; the slave is rvm_shift_seq.
interface rvm_shift_seq_if #(
    parameter int XLEN = 32
) ();
    localparam int SW = $clog2(XLEN);

    logic            in_valid;
    logic            in_ready;
    logic [2:0]      op;
    logic [XLEN-1:0] lhs;
    logic [SW-1:0]   rhs;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            busy;

    modport master (
        output in_valid, op, lhs, rhs, flush, out_ready,
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  in_valid, op, lhs, rhs, flush, out_ready,
        output in_ready, out_valid, result, busy
    );
endinterface

// File: rtl/rvm_shift_seq.sv
// Iterative shift/rotate unit: moves the operand by at most STEP bit
// positions per clock until the requested amount is consumed, then holds
// the result under a valid/ready handshake until the consumer takes it.
module rvm_shift_seq #(
    parameter int XLEN = 32,
    parameter int STEP = 1
) (
    input  logic           clk,
    input  logic           resetn,
    rvm_shift_seq_if.slave bus
);
    localparam int SW = $clog2(XLEN);
    // One extra bit so that STEP == XLEN is representable.
    localparam logic [SW:0] STEP_K = (SW+1)'(STEP);
    localparam logic [SW:0] XLEN_K = (SW+1)'(XLEN);

    localparam logic [2:0] OP_SLL = 3'b001;
    localparam logic [2:0] OP_SRL = 3'b010;
    localparam logic [2:0] OP_SRA = 3'b011;
    localparam logic [2:0] OP_ROL = 3'b100;
    localparam logic [2:0] OP_ROR = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          state_r, state_nxt_s;
    logic [XLEN-1:0] work_r, work_nxt_s;
    logic [SW-1:0]   cnt_r, cnt_nxt_s;
    logic [2:0]      op_r, op_nxt_s;
    logic            sign_r, sign_nxt_s;
    logic [XLEN-1:0] result_r, result_nxt_s;
    logic            out_valid_r;
    logic            busy_r;

    logic [SW:0]     step_s;
    logic [SW:0]     wrap_s;
    logic [XLEN-1:0] shifted_s;
    logic            final_s;
    logic            is_shift_s;

    assign bus.in_ready  = (state_r == ST_IDLE);
    assign bus.out_valid = out_valid_r;
    assign bus.result    = result_r;
    assign bus.busy      = busy_r;

    assign is_shift_s = (bus.op >= OP_SLL) && (bus.op <= OP_ROR);

    // One datapath step: k = min(STEP, remaining) applied to the working register.
    always_comb begin
        step_s    = STEP_K;
        shifted_s = work_r;
        if ({1'b0, cnt_r} < STEP_K) begin
            step_s = {1'b0, cnt_r};
        end else begin
            step_s = STEP_K;
        end
        final_s = ({1'b0, cnt_r} <= STEP_K);
        // Rotate complement amount; k never reaches XLEN because n <= XLEN-1.
        wrap_s  = XLEN_K - step_s;
        case (op_r)
            OP_SLL:  shifted_s = work_r << step_s;
            OP_SRL:  shifted_s = work_r >> step_s;
            // Sign comes from the operand captured at accept, not the working register.
            OP_SRA:  shifted_s = (work_r >> step_s) |
                                 (sign_r ? ~({XLEN{1'b1}} >> step_s) : {XLEN{1'b0}});
            OP_ROL:  shifted_s = (work_r << step_s) | (work_r >> wrap_s);
            OP_ROR:  shifted_s = (work_r >> step_s) | (work_r << wrap_s);
            default: shifted_s = work_r;
        endcase
    end

    // Next-state and next-datapath decode; flush overrides every state.
    always_comb begin
        state_nxt_s  = state_r;
        work_nxt_s   = work_r;
        cnt_nxt_s    = cnt_r;
        op_nxt_s     = op_r;
        sign_nxt_s   = sign_r;
        result_nxt_s = result_r;
        if (bus.flush) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        if (is_shift_s && (bus.rhs != {SW{1'b0}})) begin
                            state_nxt_s = ST_BUSY;
                            work_nxt_s  = bus.lhs;
                            cnt_nxt_s   = bus.rhs;
                            op_nxt_s    = bus.op;
                            sign_nxt_s  = bus.lhs[XLEN-1];
                        end else begin
                            // Zero amount passes the operand through; NOP yields zero.
                            state_nxt_s  = ST_DONE;
                            result_nxt_s = is_shift_s ? bus.lhs : {XLEN{1'b0}};
                        end
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    work_nxt_s = shifted_s;
                    cnt_nxt_s  = cnt_r - step_s[SW-1:0];
                    if (final_s) begin
                        state_nxt_s  = ST_DONE;
                        result_nxt_s = shifted_s;
                    end else begin
                        state_nxt_s = ST_BUSY;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_DONE;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
    end

    // State, datapath and registered status outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r     <= ST_IDLE;
            work_r      <= {XLEN{1'b0}};
            cnt_r       <= {SW{1'b0}};
            op_r        <= 3'b000;
            sign_r      <= 1'b0;
            result_r    <= {XLEN{1'b0}};
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            work_r      <= work_nxt_s;
            cnt_r       <= cnt_nxt_s;
            op_r        <= op_nxt_s;
            sign_r      <= sign_nxt_s;
            result_r    <= result_nxt_s;
            out_valid_r <= (state_nxt_s == ST_DONE);
            busy_r      <= (state_nxt_s != ST_IDLE);
        end
    end
endmodule

// File: tb/tb_rvm_shift_seq.sv
// Bench for rvm_shift_seq: three instances (STEP = 1, 4, 8) see the same
// request stream; each has its own scoreboard of expected result and
// expected first-valid cycle.
module tb_rvm_shift_seq;
    localparam int NI = 3;

    logic        clk;
    logic        resetn;
    logic        in_valid;
    logic        flush;
    logic        out_ready;
    logic [2:0]  op;
    logic [31:0] lhs;
    logic [4:0]  rhs;
    logic [31:0] exp_res;
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_err = 0;

    rvm_shift_seq_if #(.XLEN(32)) if1 ();
    rvm_shift_seq_if #(.XLEN(32)) if4 ();
    rvm_shift_seq_if #(.XLEN(32)) if8 ();

    rvm_shift_seq #(.XLEN(32), .STEP(1)) u1 (.clk(clk), .resetn(resetn), .bus(if1.slave));
    rvm_shift_seq #(.XLEN(32), .STEP(4)) u4 (.clk(clk), .resetn(resetn), .bus(if4.slave));
    rvm_shift_seq #(.XLEN(32), .STEP(8)) u8 (.clk(clk), .resetn(resetn), .bus(if8.slave));

    assign if1.in_valid = in_valid;  assign if4.in_valid = in_valid;  assign if8.in_valid = in_valid;
    assign if1.op = op;              assign if4.op = op;              assign if8.op = op;
    assign if1.lhs = lhs;            assign if4.lhs = lhs;            assign if8.lhs = lhs;
    assign if1.rhs = rhs;            assign if4.rhs = rhs;            assign if8.rhs = rhs;
    assign if1.flush = flush;        assign if4.flush = flush;        assign if8.flush = flush;
    assign if1.out_ready = out_ready; assign if4.out_ready = out_ready; assign if8.out_ready = out_ready;

    logic [NI-1:0] ov_a, ir_a, bz_a;
    logic [31:0]   res_a [NI];
    assign ov_a = {if8.out_valid, if4.out_valid, if1.out_valid};
    assign ir_a = {if8.in_ready, if4.in_ready, if1.in_ready};
    assign bz_a = {if8.busy, if4.busy, if1.busy};
    assign res_a[0] = if1.result;
    assign res_a[1] = if4.result;
    assign res_a[2] = if8.result;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] lhs;
        logic [4:0]  rhs;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        int          cyc;
    } sb_t;

    sb_t           sbq [NI][$];
    logic [NI-1:0] prev_ov = '0;
    vec_t          tbl [17];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int step_of(input int i);
        return (i == 0) ? 1 : ((i == 1) ? 4 : 8);
    endfunction

    function automatic int lat(input logic [2:0] o, input logic [4:0] n, input int s);
        if (o == 3'd0 || o > 3'd5 || n == 5'd0) return 1;
        return 1 + (int'(n) + s - 1) / s;
    endfunction

    // Whole-word reference: rotates via a doubled operand, SRA via >>>.
    function automatic logic [31:0] ref_shift(input logic [2:0] o, input logic [31:0] a, input logic [4:0] n);
        logic [63:0] d;
        d = {a, a};
        case (o)
            3'd1: return a << n;
            3'd2: return a >> n;
            3'd3: return 32'($signed(a) >>> n);
            3'd4: begin d = d << n; return d[63:32]; end
            3'd5: begin d = d >> n; return d[31:0]; end
            default: return 32'h0000_0000;
        endcase
    endfunction

    task automatic fail_now(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        n_err++;
        $display("FAIL %s: got 0x%08h, required 0x%08h (t=%0t)", nm, act, req, $time);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        if (act !== req) begin
            fail_now(nm, act, req);
        end else begin
            n_cmp++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard update, sampled mid-cycle on the falling edge.
    task automatic monitor();
        sb_t e;
        if (!resetn) begin
            for (int i = 0; i < NI; i++) sbq[i].delete();
            prev_ov = '0;
            return;
        end
        for (int i = 0; i < NI; i++) begin
            if (ov_a[i] && !prev_ov[i]) begin
                if (sbq[i].size() == 0) begin
                    fail_now($sformatf("unexpected_out_valid[%0d]", i), res_a[i], 32'h0);
                end else begin
                    e = sbq[i].pop_front();
                    chk($sformatf("result[%0d]", i), res_a[i], e.res);
                    chk($sformatf("latency_cycle[%0d]", i), 32'(cyc), 32'(e.cyc));
                end
            end
            if (flush) begin
                sbq[i].delete();
            end else if (in_valid && ir_a[i]) begin
                e.res = exp_res;
                e.cyc = cyc + lat(op, rhs, step_of(i));
                sbq[i].push_back(e);
            end
            prev_ov[i] = ov_a[i];
        end
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [4:0] n, input logic [31:0] e);
        int t = 0;
        while (!(&ir_a) && t < 200) begin
            step();
            t++;
        end
        if (!(&ir_a)) fail_now("issue_wait_ready", 32'(ir_a), 32'h7);
        op = o; lhs = a; rhs = n; exp_res = e;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while (!((&ir_a) && (ov_a == 3'b000)) && t < 200) begin
            step();
            t++;
        end
        if (!((&ir_a) && (ov_a == 3'b000))) fail_now("wait_idle_timeout", 32'(ir_a), 32'h7);
    endtask

    initial begin
        tbl[0]  = '{3'd3, 32'h8000_00F0, 5'd6,  32'hFE00_0003};
        tbl[1]  = '{3'd5, 32'h1234_5678, 5'd8,  32'h7812_3456};
        tbl[2]  = '{3'd4, 32'h1234_5678, 5'd4,  32'h2345_6781};
        tbl[3]  = '{3'd2, 32'h1234_5678, 5'd0,  32'h1234_5678};
        tbl[4]  = '{3'd0, 32'h1234_5678, 5'd5,  32'h0000_0000};
        tbl[5]  = '{3'd7, 32'hFFFF_FFFF, 5'd3,  32'h0000_0000};
        tbl[6]  = '{3'd2, 32'h8000_0000, 5'd31, 32'h0000_0001};
        tbl[7]  = '{3'd3, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF};
        tbl[8]  = '{3'd3, 32'h7FFF_FFFF, 5'd30, 32'h0000_0001};
        tbl[9]  = '{3'd4, 32'h8000_0001, 5'd1,  32'h0000_0003};
        tbl[10] = '{3'd5, 32'h8000_0001, 5'd1,  32'hC000_0000};
        tbl[11] = '{3'd4, 32'h1234_5678, 5'd31, 32'h091A_2B3C};
        tbl[12] = '{3'd1, 32'hDEAD_BEEF, 5'd16, 32'hBEEF_0000};
        tbl[13] = '{3'd5, 32'hDEAD_BEEF, 5'd12, 32'hEEFD_EADB};
        tbl[14] = '{3'd2, 32'hDEAD_BEEF, 5'd5,  32'h06F5_6DF7};
        tbl[15] = '{3'd3, 32'hDEAD_BEEF, 5'd5,  32'hFEF5_6DF7};
        tbl[16] = '{3'd1, 32'hA5A5_A5A5, 5'd0,  32'hA5A5_A5A5};

        fork
            forever begin
                @(negedge clk);
                monitor();
            end
        join_none

        resetn = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        op = 3'd0; lhs = 32'h0; rhs = 5'd0; exp_res = 32'h0;
        repeat (3) step();
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("rst_out_valid[%0d]", i), 32'(ov_a[i]), 32'h0);
            chk($sformatf("rst_busy[%0d]", i), 32'(bz_a[i]), 32'h0);
            chk($sformatf("rst_result[%0d]", i), res_a[i], 32'h0);
            chk($sformatf("rst_in_ready[%0d]", i), 32'(ir_a[i]), 32'h1);
        end
        resetn = 1'b1;
        step();

        // SLL 1 by 31 on STEP=1: busy c+1..c+32, out_valid first in c+32.
        issue(3'd1, 32'h0000_0001, 5'd31, 32'h8000_0000);
        for (int k = 1; k <= 33; k++) begin
            chk($sformatf("sll31_busy_c+%0d", k), 32'(bz_a[0]), (k <= 32) ? 32'h1 : 32'h0);
            chk($sformatf("sll31_valid_c+%0d", k), 32'(ov_a[0]), (k == 32) ? 32'h1 : 32'h0);
            step();
        end
        wait_idle();

        for (int v = 0; v < 17; v++) begin
            issue(tbl[v].op, tbl[v].lhs, tbl[v].rhs, tbl[v].exp);
            wait_idle();
        end

        for (int r = 0; r < 10; r++) begin
            logic [2:0]  ro;
            logic [31:0] ra;
            logic [4:0]  rn;
            ro = 3'($urandom_range(0, 7));
            ra = $urandom;
            rn = 5'($urandom_range(0, 31));
            issue(ro, ra, rn, ref_shift(ro, ra, rn));
            wait_idle();
        end

        // Backpressure: result and valid hold, new request ignored.
        out_ready = 1'b0;
        issue(3'd1, 32'h0000_0001, 5'd3, 32'h0000_0008);
        for (int t = 0; t < 40 && !(&ov_a); t++) step();
        chk("bp_all_valid", 32'(ov_a), 32'h7);
        op = 3'd2; lhs = 32'h0000_FFFF; rhs = 5'd1; exp_res = 32'h0000_7FFF;
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            for (int i = 0; i < NI; i++) begin
                chk($sformatf("bp_valid[%0d]", i), 32'(ov_a[i]), 32'h1);
                chk($sformatf("bp_in_ready[%0d]", i), 32'(ir_a[i]), 32'h0);
                chk($sformatf("bp_result[%0d]", i), res_a[i], 32'h0000_0008);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        chk("bp_release_in_ready", 32'(ir_a), 32'h7);
        chk("bp_release_valid", 32'(ov_a), 32'h0);

        // Flush in the third BUSY cycle of SLL by 20.
        issue(3'd1, 32'h0000_0001, 5'd20, 32'h0010_0000);
        step();
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("flush_valid[%0d]", i), 32'(ov_a[i]), 32'h0);
            chk($sformatf("flush_in_ready[%0d]", i), 32'(ir_a[i]), 32'h1);
            chk($sformatf("flush_busy[%0d]", i), 32'(bz_a[i]), 32'h0);
            chk($sformatf("flush_result_frozen[%0d]", i), res_a[i], 32'h0000_0008);
        end
        repeat (6) step();

        // Flush coincident with a request in IDLE drops the request.
        op = 3'd1; lhs = 32'h0000_0001; rhs = 5'd2; exp_res = 32'h0000_0004;
        in_valid = 1'b1;
        flush = 1'b1;
        step();
        in_valid = 1'b0;
        flush = 1'b0;
        chk("flush_req_busy", 32'(bz_a), 32'h0);
        chk("flush_req_valid", 32'(ov_a), 32'h0);
        chk("flush_req_in_ready", 32'(ir_a), 32'h7);
        repeat (5) step();

        // Asynchronous reset between edges while busy.
        issue(3'd1, 32'h0000_0001, 5'd20, 32'h0010_0000);
        step();
        step();
        #1 resetn = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("async_rst_valid[%0d]", i), 32'(ov_a[i]), 32'h0);
            chk($sformatf("async_rst_busy[%0d]", i), 32'(bz_a[i]), 32'h0);
            chk($sformatf("async_rst_result[%0d]", i), res_a[i], 32'h0);
            chk($sformatf("async_rst_in_ready[%0d]", i), 32'(ir_a[i]), 32'h1);
        end
        @(posedge clk);
        #2 resetn = 1'b1;
        step();
        issue(3'd5, 32'h1234_5678, 5'd8, 32'h7812_3456);
        wait_idle();

        repeat (3) step();
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("scoreboard_drained[%0d]", i), 32'(sbq[i].size()), 32'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/rvm_shift_seq.md
# rvm_shift_seq

Iterative, parametrised shift/rotate unit for the multi-cycle core. It replaces the single-cycle 32-bit barrel shifter with a datapath of configurable width. The datapath shifts by at most `STEP` bit positions per clock, which trades latency for area. It adds rotate-left and rotate-right modes, and a valid/ready handshake on both sides so the core FSM can issue an operation and wait for the result.

## Interface
Parameters:
- `XLEN`, 32 — operand/result width; power of two, at least 8.
- `STEP`, 1 — maximum bit positions shifted per cycle; power of two, 1 to `XLEN`.
- `SW`, $clog2(`XLEN`) — shift-amount width; derived, not overridden.

Ports:
- `clk`  in  1  — sole clock, rising edge.
- `resetn`  in  1  — asynchronous, active-low reset.
- `in_valid`  in  1  — request present.
- `in_ready`  out  1  — unit can accept a request.
- `op`  in  3  — operation: 000 NOP, 001 SLL, 010 SRL, 011 SRA, 100 ROL, 101 ROR; 110 and 111 are treated as NOP.
- `lhs`  in  `XLEN`  — value to shift.
- `rhs`  in  `SW`  — shift amount; only the low `SW` bits are used (upper bits are truncated by the caller).
- `flush`  in  1  — synchronous abort of any in-flight operation.
- `out_valid`  out  1  — result available.
- `out_ready`  in  1  — consumer accepts the result.
- `result`  out  `XLEN`  — shifted value.
- `busy`  out  1  — high in states BUSY or DONE.

## Operation
- FSM states:
  - IDLE: `in_ready`=1, `out_valid`=0.
  - BUSY: shifting.
  - DONE: `out_valid`=1.
- IDLE → BUSY on `in_valid & in_ready` with amount n = `rhs` > 0 and a shift/rotate op.
  - Latch `op` and `lhs` into the working register.
  - Latch n into the remaining count.
- IDLE → DONE directly on accept when n = 0 or op is NOP.
  - n = 0: `result` = `lhs`.
  - NOP: `result` = 0, regardless of `lhs`/`rhs`.
- BUSY, each cycle:
  - k = min(`STEP`, remaining).
  - Working register shifted by k per op:
    - SLL: zero fill at the LSB end.
    - SRL: zero fill at the MSB end.
    - SRA: fill with the original bit `XLEN`-1.
    - ROL/ROR: bits leaving one end enter the other.
  - remaining decrements by k.
  - When remaining = k, the step is final and the next state is DONE.
- DONE:
  - `result` = working register, held stable while `out_ready`=0.
  - On `out_valid & out_ready`, go to IDLE.
- `in_ready` is high only in IDLE, and is driven combinationally from state. Requests presented in BUSY or DONE are not accepted and must be held by the requester.
- `flush`:
  - In any state, forces IDLE at the next edge and clears `out_valid`.
  - `result` is frozen at its last value.
  - A request presented in IDLE in the same cycle as `flush` is dropped; `flush` wins.
- Arithmetic:
  - All shifting is modulo-`XLEN` in amount. n ≤ `XLEN`-1 always.
  - SRA sign is taken from the operand at accept, not re-sampled.
  - ROL/ROR by n equals ROR/ROL by `XLEN`-n.

## Timing
- Reset, asynchronous while `resetn`=0:
  - state IDLE.
  - `out_valid`=0, `busy`=0, `result`=0.
  - working register and count = 0.
  - `in_ready`=1.
- Accept in cycle c → `out_valid` first high in cycle c+1+ceil(n/`STEP`).
  - NOP or n=0: cycle c+1.
  - `STEP`=`XLEN`: every op completes by c+2.
- Result consumed in cycle d (`out_valid & out_ready`) → `in_ready` high in cycle d+1. There is a single bubble between back-to-back operations.
- `out_valid` never deasserts without a handshake, `flush`, or reset. `result` changes only on the final BUSY step or on an accept that goes directly to DONE.
- Reset asserted mid-operation aborts immediately. No partial result is ever presented.
- `busy` is registered-state decode and has no combinational path from inputs.

## Test plan
- `XLEN`=32, `STEP`=1, SLL with `lhs`=0x0000_0001, `rhs`=31 → `result`=0x8000_0000. `out_valid` first in cycle c+32; `busy` high cycles c+1 to c+32.
- `STEP`=4, SRA with `lhs`=0x8000_00F0, `rhs`=6 → `result`=0xFE00_0003. `out_valid` in cycle c+3 (steps of 4, then 2).
- `STEP`=8, ROR with `lhs`=0x1234_5678, `rhs`=8 → 0x7812_3456. ROL with `rhs`=4 → 0x2345_6781. SRL with `rhs`=0 → 0x1234_5678 in cycle c+1. NOP → 0 in cycle c+1.
- Backpressure: `out_ready`=0 for 5 cycles after `out_valid` → `result` and `out_valid` stable, `in_ready`=0, new `in_valid` ignored. `out_ready`=1 → `in_ready` high in the next cycle.
- `flush` in the 3rd BUSY cycle of a `STEP`=1, n=20 SLL → IDLE at the next edge, no `out_valid`. `flush` coincident with `in_valid` in IDLE → request dropped.
- `resetn` pulsed low mid-BUSY, asynchronously between edges → `out_valid`, `busy`, `result` = 0 immediately and `in_ready`=1. The first request after release completes with correct latency.
